// File: rtl/keccak_x_heep_pkg.sv
// Shared types for the Keccak register-port initiator: register bus structs,
// queued command format and FSM state encoding.
package keccak_x_heep_pkg;

  localparam int KECCAK_STATE_WORDS = 50;
  localparam int KECCAK_CMD_LEN_W   = 7;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [31:0]                 addr;
    logic                        write;
    logic [KECCAK_CMD_LEN_W-1:0] len;
  } keccak_reg_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_ISSUE,
    ST_RESP
  } keccak_reg_state_e;

endpackage

// File: rtl/keccak_reg_cmd_fifo.sv
// Synchronous-reset FIFO for queued register commands; push while full is
// accepted only when a pop happens in the same cycle.
module keccak_reg_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW:0]    wptr_q, rptr_q;
  logic           push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_en)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/keccak_reg_master.sv
// Register-bus initiator: pops queued commands and runs single or
// auto-incrementing burst reads/writes against a reg_req_t/reg_rsp_t slave.
//   state  | meaning
//   IDLE   | waiting for a command (FIFO head or direct bypass when empty)
//   WDATA  | waiting for one write-data beat
//   ISSUE  | request valid on the bus, timeout counter running
//   RESP   | beat result presented, waiting for rsp_ready_i
module keccak_reg_master
  import keccak_x_heep_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = KECCAK_CMD_LEN_W,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic             cmd_write_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [31:0]      wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_error_o,
  output logic             rsp_last_o,
  output reg_req_t         reg_req_o,
  input  reg_rsp_t         reg_rsp_i,
  output logic             busy_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  keccak_reg_state_e state_q, state_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              write_q, write_d, err_q, err_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  keccak_reg_cmd_t cmd_in, fifo_head, head;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop, bypass, idle;

  always_comb begin
    cmd_in       = '0;
    cmd_in.addr  = cmd_addr_i;
    cmd_in.write = cmd_write_i;
    cmd_in.len   = KECCAK_CMD_LEN_W'(cmd_len_i);
  end

  // An idle master with an empty FIFO takes the incoming command directly.
  assign idle        = (state_q == ST_IDLE);
  assign fifo_pop    = idle && !fifo_empty;
  assign bypass      = idle && fifo_empty && cmd_valid_i;
  assign cmd_ready_o = (!fifo_full || fifo_pop) && !rst_i;
  assign fifo_push   = cmd_valid_i && cmd_ready_o && !bypass;
  assign head        = fifo_empty ? cmd_in : fifo_head;

  keccak_reg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (keccak_reg_cmd_t)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (cmd_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      beats_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      beats_q <= beats_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    err_d   = err_q;
    beats_d = beats_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop || bypass) begin
          addr_d  = head.addr & ~32'h3;
          write_d = head.write;
          beats_d = (head.len[LEN_W-1:0] == '0) ? LEN_W'(1) : head.len[LEN_W-1:0];
          tmo_d   = '0;
          state_d = head.write ? ST_WDATA : ST_ISSUE;
        end
      end
      ST_WDATA: begin
        if (wdata_valid_i) begin
          wdata_d = wdata_i;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reg_rsp_i.ready) begin
          rdata_d = write_q ? 32'h0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = ST_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          beats_d = beats_q - LEN_W'(1);
          addr_d  = addr_q + 32'd4;
          tmo_d   = '0;
          if (beats_q == LEN_W'(1)) state_d = ST_IDLE;
          else                      state_d = write_q ? ST_WDATA : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = (state_q == ST_ISSUE) ? 4'hF : 4'h0;
    reg_req_o.valid = (state_q == ST_ISSUE);
  end

  assign wdata_ready_o = (state_q == ST_WDATA);
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_rdata_o   = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_error_o   = rsp_valid_o && err_q;
  assign rsp_last_o    = rsp_valid_o && (beats_q == LEN_W'(1));
  assign busy_o        = !idle || !fifo_empty;

endmodule

// File: tb/tb_keccak_reg_master.sv
// Self-checking bench: randomised slave/handshake behaviour against a
// beat-level scoreboard built from each queued command.
module tb_keccak_reg_master;
  import keccak_x_heep_pkg::*;

  localparam int LEN_W   = 7;
  localparam int TIMEOUT = 255;
  localparam int NEVER   = 100000;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [31:0]      cmd_addr_i = '0;
  logic             cmd_write_i = 1'b0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic             wdata_valid_i = 1'b0;
  logic             wdata_ready_o;
  logic [31:0]      wdata_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_error_o;
  logic             rsp_last_o;
  reg_req_t         reg_req_o;
  reg_rsp_t         reg_rsp_i = '0;
  logic             busy_o;

  always #5 clk_i = ~clk_i;

  keccak_reg_master #(.FIFO_DEPTH(4), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i, .rst_i, .cmd_valid_i, .cmd_ready_o, .cmd_addr_i, .cmd_write_i,
    .cmd_len_i, .wdata_valid_i, .wdata_ready_o, .wdata_i, .rsp_valid_o,
    .rsp_ready_i, .rsp_rdata_o, .rsp_error_o, .rsp_last_o, .reg_req_o,
    .reg_rsp_i, .busy_o
  );

  typedef struct packed { logic [31:0] addr; logic write; logic [LEN_W-1:0] len; } cmd_s;
  typedef struct packed { logic [31:0] addr; logic write; logic last; } beat_s;
  typedef struct packed { logic [31:0] rdata; logic err; logic last; } rsp_s;

  cmd_s        cmd_q[$];
  beat_s       beat_q[$];
  rsp_s        rsp_q[$];
  logic [31:0] wq[$];
  logic [31:0] wd_pat[$];
  int          wait_plan[$];

  int   n_tests = 0, n_fail = 0;
  int   slv_wait = 0, rsp_stall = 0, cur_wait = 0, cur_stall = 0;
  int   scnt = 0, rcnt = 0, vcyc = 0, wd_cnt = 0, tmo_cnt = 0;
  bit   err_en = 0, wd_rand = 0, rd_fix_en = 0, prev_valid = 0, last_cmd_ready = 0;
  logic [31:0] rd_fix = '0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic w, input int len);
    cmd_s c;
    c.addr = a; c.write = w; c.len = LEN_W'(len);
    cmd_q.push_back(c);
  endtask

  task automatic step();
    cmd_s  c;
    beat_s b;
    rsp_s  e;
    int    n;
    @(negedge clk_i);
    if (cmd_q.size() > 0) begin
      cmd_valid_i = 1'b1; cmd_addr_i = cmd_q[0].addr;
      cmd_write_i = cmd_q[0].write; cmd_len_i = cmd_q[0].len;
    end else begin
      cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_write_i = 1'b0; cmd_len_i = '0;
    end
    wdata_valid_i = wd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    wdata_i = (wd_pat.size() > 0) ? wd_pat[0] : $urandom;
    if (reg_req_o.valid) begin
      if (scnt == 0)
        cur_wait = (wait_plan.size() > 0) ? wait_plan.pop_front()
                 : ((slv_wait < 0) ? $urandom_range(0, 3) : slv_wait);
      reg_rsp_i.ready = (scnt == cur_wait);
      scnt = reg_rsp_i.ready ? 0 : scnt + 1;
    end else begin
      reg_rsp_i.ready = 1'b0;
      scnt = 0;
    end
    reg_rsp_i.rdata = rd_fix_en ? rd_fix : $urandom;
    reg_rsp_i.error = err_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (rsp_valid_o) begin
      if (rcnt == 0) cur_stall = (rsp_stall < 0) ? $urandom_range(0, 2) : rsp_stall;
      rsp_ready_i = (rcnt == cur_stall);
      rcnt = rsp_ready_i ? 0 : rcnt + 1;
    end else begin
      rsp_ready_i = 1'b0;
      rcnt = 0;
    end
    #1;
    last_cmd_ready = cmd_ready_o;
    if (cmd_valid_i && cmd_ready_o) begin
      c = cmd_q.pop_front();
      n = (c.len == 0) ? 1 : int'(c.len);
      for (int i = 0; i < n; i++) begin
        b.addr = (c.addr & ~32'h3) + 32'(4 * i);
        b.write = c.write;
        b.last = (i == n - 1);
        beat_q.push_back(b);
      end
    end
    if (wdata_valid_i && wdata_ready_o) begin
      wq.push_back(wdata_i);
      if (wd_pat.size() > 0) void'(wd_pat.pop_front());
      wd_cnt++;
    end
    if (rsp_valid_o) check_eq("no_req_in_resp", reg_req_o.valid, 0);
    if (reg_req_o.valid) begin
      vcyc++;
      if (beat_q.size() == 0) check_eq("req_unexpected", 1, 0);
      else begin
        check_eq("req_addr", reg_req_o.addr, beat_q[0].addr);
        if (reg_rsp_i.ready) begin
          b = beat_q.pop_front();
          check_eq("req_write", reg_req_o.write, b.write);
          check_eq("req_wstrb", reg_req_o.wstrb, 4'hF);
          check_eq("issue_len", vcyc, cur_wait + 1);
          if (b.write) begin
            if (wq.size() == 0) check_eq("wdata_missing", 1, 0);
            else check_eq("req_wdata", reg_req_o.wdata, wq.pop_front());
          end
          e.rdata = b.write ? 32'h0 : reg_rsp_i.rdata;
          e.err = reg_rsp_i.error;
          e.last = b.last;
          rsp_q.push_back(e);
          vcyc = 0;
        end
      end
    end else if (prev_valid) begin
      check_eq("tmo_len", vcyc, TIMEOUT);
      tmo_cnt++;
      if (beat_q.size() > 0) begin
        b = beat_q.pop_front();
        e.rdata = 32'h0; e.err = 1'b1; e.last = b.last;
        rsp_q.push_back(e);
      end
      vcyc = 0;
    end
    prev_valid = reg_req_o.valid && !reg_rsp_i.ready;
    if (rsp_valid_o && rsp_ready_i) begin
      if (rsp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
      else begin
        e = rsp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata_o, e.rdata);
        check_eq("rsp_error", rsp_error_o, e.err);
        check_eq("rsp_last", rsp_last_o, e.last);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (cmd_q.size() == 0 && beat_q.size() == 0 && rsp_q.size() == 0 && !busy_o) return;
      step();
    end
    check_eq({tag, "_hang"}, 1, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rst_i = 1'b1; cmd_valid_i = 1'b0; wdata_valid_i = 1'b0;
    rsp_ready_i = 1'b0; reg_rsp_i = '0;
    repeat (cycles) @(negedge clk_i);
    #1;
    check_eq("rst_req", reg_req_o, 0);
    check_eq("rst_cmd_ready", cmd_ready_o, 0);
    check_eq("rst_wdata_ready", wdata_ready_o, 0);
    check_eq("rst_rsp", {rsp_valid_o, rsp_rdata_o, rsp_error_o, rsp_last_o}, 0);
    check_eq("rst_busy", busy_o, 0);
    cmd_q.delete(); beat_q.delete(); rsp_q.delete(); wq.delete(); wd_pat.delete();
    wait_plan.delete();
    scnt = 0; rcnt = 0; vcyc = 0; prev_valid = 0;
    rst_i = 1'b0;
    #1;
    check_eq("rdy_after_rst", cmd_ready_o, 1);
  endtask

  initial begin
    do_reset(3);

    // Single write, slave ready in the same cycle.
    slv_wait = 0; rsp_stall = 0; err_en = 0; wd_rand = 0; wd_cnt = 0;
    wd_pat.push_back(32'hDEADBEEF);
    push_cmd(32'h10, 1'b1, 1);
    wait_done("single_wr", 50);
    check_eq("single_wr_beats", wd_cnt, 1);

    // Single read, three slave wait cycles, fixed read data.
    rd_fix_en = 1; rd_fix = 32'h12345678; slv_wait = 3;
    push_cmd(32'h20, 1'b0, 1);
    wait_done("single_rd", 50);
    rd_fix_en = 0;

    // Full Keccak state load.
    slv_wait = 0; wd_cnt = 0;
    push_cmd(32'h0, 1'b1, KECCAK_STATE_WORDS);
    wait_done("state_load", 400);
    check_eq("state_load_beats", wd_cnt, KECCAK_STATE_WORDS);

    // Read that never gets ready, followed by a normal one.
    tmo_cnt = 0;
    wait_plan.push_back(NEVER);
    push_cmd(32'h40, 1'b0, 1);
    push_cmd(32'h44, 1'b0, 1);
    wait_done("timeout", 600);
    check_eq("timeout_count", tmo_cnt, 1);

    // Stalled responses with commands piling up behind the burst.
    rsp_stall = 5;
    push_cmd(32'h100, 1'b0, 4);
    for (int i = 0; i < 20 && !rsp_valid_o; i++) step();
    check_eq("stall_resp_seen", rsp_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'h400 + 32'(16 * i), 1'b0, 1);
      step();
      check_eq("cmd_ready_fill", last_cmd_ready, (i < 4));
    end
    wait_done("stall", 300);

    // Reset in the middle of a 10-beat write burst, then a fresh read.
    rsp_stall = -1; slv_wait = -1; wd_rand = 1;
    push_cmd(32'h200, 1'b1, 10);
    repeat (15) step();
    do_reset(1);
    push_cmd(32'h300, 1'b0, 3);
    wait_done("post_rst", 100);

    // Randomised mix including zero length, address wrap and max length.
    err_en = 1;
    push_cmd(32'h500, 1'b0, 0);
    for (int i = 0; i < 40; i++)
      push_cmd((i % 5 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 8));
    push_cmd(32'hFFFF_FF00, 1'b1, 127);
    wait_done("random", 20000);

    check_eq("end_beats_left", beat_q.size(), 0);
    check_eq("end_wdata_left", wq.size(), 0);
    check_eq("end_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
